// File: rtl/buffer_circ_pkg.sv
// Width helpers and shared types for the variable-ratio circular buffer.
package buffer_circ_pkg;

  // Wide unsigned type for lane counts and occupancy arithmetic, so that
  // comparisons between differently sized fields never truncate.
  typedef logic [15:0] lane_cnt_t;

  // Bits needed to hold values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to index 0..depth-1.
  function automatic int ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/buffer_circ_ptr.sv
// Modulo-DEPTH pointer advance. Because a step never exceeds DEPTH, the sum
// is below 2*DEPTH, so a single conditional subtract replaces the modulo.
module buffer_circ_ptr
  import buffer_circ_pkg::*;
#(
  parameter int DEPTH    = 9,
  parameter int MAX_STEP = 4
) (
  input  logic [ptr_w(DEPTH)-1:0]    ptr,
  input  logic [cnt_w(MAX_STEP)-1:0] step,
  output logic [ptr_w(DEPTH)-1:0]    ptr_next
);

  localparam int PW = ptr_w(DEPTH);

  lane_cnt_t sum;

  // Add the step and fold back into 0..DEPTH-1.
  always_comb begin
    sum = lane_cnt_t'(ptr) + lane_cnt_t'(step);
    if (sum >= lane_cnt_t'(DEPTH)) sum = sum - lane_cnt_t'(DEPTH);
    ptr_next = PW'(sum);
  end

endmodule

// File: rtl/buffer_circ_var.sv
// Circular FIFO with variable-width write (1..PAR_WRITE words) and read
// (1..PAR_READ words) per cycle, arbitrary depth, registered read data.
// Acceptance is decided from the occupancy before the edge; there is no
// bypass between the write and read sides within one cycle.
module buffer_circ_var
  import buffer_circ_pkg::*;
#(
  parameter int SIZE      = 16,
  parameter int DEPTH     = 9,
  parameter int PAR_WRITE = 4,
  parameter int PAR_READ  = 2,
  parameter int AFULL_TH  = DEPTH - 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wen,
  input  logic [cnt_w(PAR_WRITE)-1:0]    wcnt,
  input  logic [PAR_WRITE*SIZE-1:0]      din,
  input  logic                           ren,
  input  logic [cnt_w(PAR_READ)-1:0]     rcnt,
  output logic [PAR_READ*SIZE-1:0]       dout,
  output logic                           valid,
  output logic [cnt_w(PAR_READ)-1:0]     vcnt,
  output logic                           ready,
  output logic                           full,
  output logic                           empty,
  output logic                           almost_full,
  output logic [cnt_w(DEPTH)-1:0]        count,
  output logic                           wr_err,
  output logic                           rd_err
);

  localparam int CW       = cnt_w(DEPTH);
  localparam int PW       = ptr_w(DEPTH);
  localparam int MAX_STEP = (PAR_WRITE > PAR_READ) ? PAR_WRITE : PAR_READ;
  localparam int SW       = cnt_w(MAX_STEP);

  logic [SIZE-1:0] mem [DEPTH];

  logic [PW-1:0] wptr, rptr, wptr_nxt, rptr_nxt;
  logic [SW-1:0] wstep, rstep;
  logic [PW-1:0] waddr [PAR_WRITE];
  logic [PW-1:0] raddr [PAR_READ];
  logic [PAR_READ*SIZE-1:0] rd_data;

  lane_cnt_t occ, free, wc, rc, acc_w, acc_r;
  logic      wr_req, rd_req, wr_acc, rd_acc;

  assign occ  = lane_cnt_t'(count);
  assign free = lane_cnt_t'(DEPTH) - occ;
  assign wc   = lane_cnt_t'(wcnt);
  assign rc   = lane_cnt_t'(rcnt);

  assign full        = (occ == lane_cnt_t'(DEPTH));
  assign empty       = (occ == '0);
  assign almost_full = (occ >= lane_cnt_t'(AFULL_TH));
  assign ready       = (free >= lane_cnt_t'(PAR_WRITE));

  // All-or-nothing acceptance against pre-edge occupancy; out-of-range
  // counts are treated as rejected requests.
  always_comb begin
    wr_req = wen && (wcnt != '0);
    rd_req = ren && (rcnt != '0);
    wr_acc = wr_req && (wc <= lane_cnt_t'(PAR_WRITE)) && (wc <= free);
    rd_acc = rd_req && (rc <= lane_cnt_t'(PAR_READ)) && (rc <= occ);
    acc_w  = wr_acc ? wc : '0;
    acc_r  = rd_acc ? rc : '0;
    wstep  = SW'(acc_w);
    rstep  = SW'(acc_r);
  end

  buffer_circ_ptr #(.DEPTH(DEPTH), .MAX_STEP(MAX_STEP)) u_wptr (
    .ptr      (wptr),
    .step     (wstep),
    .ptr_next (wptr_nxt)
  );

  buffer_circ_ptr #(.DEPTH(DEPTH), .MAX_STEP(MAX_STEP)) u_rptr (
    .ptr      (rptr),
    .step     (rstep),
    .ptr_next (rptr_nxt)
  );

  // Per-lane addresses; lane offsets are below DEPTH so one subtract wraps.
  always_comb begin
    lane_cnt_t t;
    t = '0;
    for (int i = 0; i < PAR_WRITE; i++) begin
      t = lane_cnt_t'(wptr) + lane_cnt_t'(i);
      if (t >= lane_cnt_t'(DEPTH)) t = t - lane_cnt_t'(DEPTH);
      waddr[i] = PW'(t);
    end
    for (int i = 0; i < PAR_READ; i++) begin
      t = lane_cnt_t'(rptr) + lane_cnt_t'(i);
      if (t >= lane_cnt_t'(DEPTH)) t = t - lane_cnt_t'(DEPTH);
      raddr[i] = PW'(t);
    end
  end

  // Gather the requested read lanes; lanes beyond rcnt stay zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < PAR_READ; i++) begin
      if (lane_cnt_t'(i) < rc) rd_data[i*SIZE +: SIZE] = mem[raddr[i]];
    end
  end

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < PAR_WRITE; i++) begin
        if (lane_cnt_t'(i) < wc) mem[waddr[i]] <= din[i*SIZE +: SIZE];
      end
    end
  end

  // Pointers, occupancy and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      wr_err <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      wptr   <= wptr_nxt;
      rptr   <= rptr_nxt;
      count  <= CW'(occ + acc_w - acc_r);
      wr_err <= wr_req && !wr_acc;
      rd_err <= rd_req && !rd_acc;
    end
  end

  // Registered read port; dout holds its value when no read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout  <= '0;
      valid <= 1'b0;
      vcnt  <= '0;
    end else begin
      valid <= rd_acc;
      if (rd_acc) begin
        dout <= rd_data;
        vcnt <= rcnt;
      end else begin
        vcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_buffer_circ_var.sv
// Randomized and directed bench for buffer_circ_var with a queue-based
// reference model and a scoreboard checked by an independent monitor.
module tb_buffer_circ_var;

  localparam int DEPTH = 9;
  localparam int PW    = 4;
  localparam int PR    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen;
  logic [2:0]  wcnt;
  logic [63:0] din;
  logic        ren;
  logic [1:0]  rcnt;
  logic [31:0] dout;
  logic        valid;
  logic [1:0]  vcnt;
  logic        ready, full, empty, almost_full;
  logic [3:0]  count;
  logic        wr_err, rd_err;

  buffer_circ_var dut (
    .clk(clk), .rst(rst), .wen(wen), .wcnt(wcnt), .din(din),
    .ren(ren), .rcnt(rcnt), .dout(dout), .valid(valid), .vcnt(vcnt),
    .ready(ready), .full(full), .empty(empty), .almost_full(almost_full),
    .count(count), .wr_err(wr_err), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  vc;
    logic [31:0] d;
  } exp_t;

  logic [15:0] q[$];
  exp_t        sb[$];
  exp_t        me;
  int          checks = 0;
  int          errors = 0;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: whenever the DUT presents read data, pop and compare.
  always @(negedge clk) begin
    if (!rst && valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 64'(valid), 64'd0);
      end else begin
        me = sb.pop_front();
        chk("vcnt", 64'(vcnt), 64'(me.vc));
        chk("dout", 64'(dout), 64'(me.d));
      end
    end
  end

  // One clock of stimulus; the model decides acceptance from the
  // occupancy before the edge and queues the expected read result.
  task automatic step(input bit we, input int wc, input logic [63:0] d,
                      input bit re, input int rc);
    int   n;
    bit   wa, ra;
    exp_t e;
    wen  = we;  wcnt = wc[2:0]; din = d;
    ren  = re;  rcnt = rc[1:0];
    n  = q.size();
    wa = we && wc != 0 && wc <= PW && wc <= DEPTH - n;
    ra = re && rc != 0 && rc <= PR && rc <= n;
    @(posedge clk); #1;
    if (ra) begin
      e.vc = rc[1:0];
      e.d  = '0;
      for (int i = 0; i < rc; i++) e.d[i*16 +: 16] = q.pop_front();
      sb.push_back(e);
    end
    if (wa) for (int i = 0; i < wc; i++) q.push_back(d[i*16 +: 16]);
    n = q.size();
    chk("count", 64'(count), 64'(n));
    chk("flags", 64'({ready, full, empty, almost_full}),
        64'({(DEPTH - n) >= PW, n == DEPTH, n == 0, n >= DEPTH - 2}));
    chk("wr_err", 64'(wr_err), 64'(we && wc != 0 && !wa));
    chk("rd_err", 64'(rd_err), 64'(re && rc != 0 && !ra));
    chk("valid", 64'(valid), 64'(ra));
    wen = 1'b0; wcnt = '0; ren = 1'b0; rcnt = '0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() > 0; k++)
      step(0, 0, '0, 1, (q.size() >= 2) ? 2 : 1);
  endtask

  initial begin
    int   w, wc, rc, k;
    int   pat[4];
    logic [63:0] d;
    pat = '{3, 1, 4, 2};

    rst = 1'b1; wen = 1'b0; wcnt = '0; din = '0; ren = 1'b0; rcnt = '0;
    #3;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_flags", 64'({ready, full, empty, almost_full}), 64'b1010);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_valid", 64'({valid, vcnt, wr_err, rd_err}), 64'd0);
    @(negedge clk); rst = 1'b0;

    // Basic write then narrower reads.
    step(1, 4, {16'd4, 16'd3, 16'd2, 16'd1}, 0, 0);
    step(0, 0, '0, 1, 2);
    chk("plan_rd2", 64'(dout), 64'h0002_0001);
    chk("plan_cnt2", 64'(count), 64'd2);
    step(0, 0, '0, 1, 1);
    chk("plan_rd1", 64'(dout), 64'h0000_0003);
    drain();
    step(0, 0, '0, 0, 0);

    // Fill to the edge of full.
    step(1, 4, {16'd8, 16'd7, 16'd6, 16'd5}, 0, 0);
    step(1, 4, {16'd12, 16'd11, 16'd10, 16'd9}, 0, 0);
    chk("plan_afull", 64'({ready, almost_full}), 64'b01);
    step(1, 4, {16'd99, 16'd99, 16'd99, 16'd99}, 0, 0);
    chk("plan_wr_rej", 64'({wr_err, count}), 64'h18);
    step(1, 1, {48'd0, 16'd13}, 0, 0);
    chk("plan_full", 64'({full, count}), 64'h19);
    step(1, 2, {32'd0, 16'd77, 16'd77}, 1, 2);
    chk("plan_rw_full", 64'({wr_err, valid, count}), 64'h37);
    drain();

    // Stream 1..20 with mixed widths across several wraps.
    w = 1; k = 0;
    while (w <= 20 && k < 100) begin
      wc = pat[k % 4];
      if (wc > 21 - w) wc = 21 - w;
      d = {$urandom, $urandom};
      for (int i = 0; i < wc; i++) d[i*16 +: 16] = 16'(w + i);
      rc = (k % 2) + 1;
      if (wc <= DEPTH - q.size()) begin
        step(1, wc, d, 1, rc);
        w += wc;
      end else begin
        step(0, 0, '0, 1, rc);
      end
      k++;
    end
    drain();

    // Read wider than occupancy is rejected.
    step(1, 1, {48'd0, 16'h00AA}, 0, 0);
    step(0, 0, '0, 1, 2);
    chk("plan_rd_rej", 64'({rd_err, valid, count}), 64'h21);
    step(0, 0, '0, 1, 1);
    chk("plan_last", 64'({dout, vcnt, empty}), 64'({32'h0000_00AA, 2'd1, 1'b1}));

    // Asynchronous reset mid-fill discards contents.
    step(1, 3, {16'd0, 16'h0C3, 16'h0C2, 16'h0C1}, 0, 0);
    step(1, 2, {32'd0, 16'h0C5, 16'h0C4}, 0, 0);
    step(0, 0, '0, 0, 0);
    rst = 1'b1; #1;
    chk("async_rst", 64'({count, empty, valid}), 64'b0_0000_1_0);
    q.delete(); sb.delete();
    @(negedge clk); rst = 1'b0;
    step(0, 0, '0, 1, 1);
    step(1, 2, {32'd0, 16'h0D2, 16'h0D1}, 0, 0);
    step(0, 0, '0, 1, 2);

    // Randomized traffic including out-of-range counts.
    for (int n = 0; n < 400; n++) begin
      d = {$urandom, $urandom};
      step(($urandom % 4) != 0, $urandom_range(0, 7), d,
           ($urandom % 3) != 0, $urandom_range(0, 3));
    end
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "timeout");
  end

endmodule
